// File: rtl/video_gen_pkg.sv
// Shared types and constants for the video-generation engines.
// Holds the scorer state encoding and the Galois LFSR step.
package video_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    READY,
    EVAL,
    DONE
  } scorer_state_t;

  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam int SCORE_W = 8;

  // Right-shifting Galois step: feedback taps applied when bit 0 falls out
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {1'b0, q[7:1]} ^ (q[0] ? LFSR_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR with seed load and single-step advance.
// A zero seed is replaced by 8'h01 so the register never locks up.
module lfsr8
  import video_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 8'h01;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/motion_clip_scorer.sv
// Synthesises a pseudo-random motion clip from a prompt and scores it
// as the mean absolute sample-to-sample step of the clip.
module motion_clip_scorer
  import video_gen_pkg::*;
#(
  parameter int         N_SAMPLES = 16,
  parameter int         SAMPLE_W  = 8,
  parameter logic [7:0] SEED_XOR  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                make,
  input  logic                check,
  input  logic [SAMPLE_W-1:0] prmt,
  output logic [SAMPLE_W-1:0] score,
  output logic                score_valid,
  output logic                busy
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int PROD_W = SAMPLE_W + 8;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  scorer_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SAMPLE_W-1:0] prmt_q, prmt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0] score_q, score_d;
  logic score_valid_q, score_valid_d;
  logic busy_q, busy_d;
  logic clip_ok_q, clip_ok_d;
  logic chk_pend_q, chk_pend_d;

  logic [SAMPLE_W-1:0] buf_q [N_SAMPLES];
  logic buf_we;

  logic lfsr_load;
  logic lfsr_step;
  logic [7:0] seed;
  logic [7:0] lfsr_q;

  logic [PROD_W-1:0] prod;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] prv;
  logic [SAMPLE_W-1:0] diff;

  assign seed = prmt[7:0] ^ SEED_XOR;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Upper byte of the 8xSAMPLE_W product scales noise by the prompt
  assign prod = {{SAMPLE_W{1'b0}}, lfsr_q} * {8'h00, prmt_q};
  assign sample = SAMPLE_W'(prod >> 8);

  assign cur = buf_q[idx_q];
  assign prv = buf_q[idx_q - ONE];
  assign diff = (cur >= prv) ? (cur - prv) : (prv - cur);

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    prmt_d = prmt_q;
    acc_d = acc_q;
    score_d = score_q;
    score_valid_d = 1'b0;
    clip_ok_d = clip_ok_q;
    chk_pend_d = chk_pend_q;
    buf_we = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (make) begin
          prmt_d = prmt;
          lfsr_load = 1'b1;
          idx_d = '0;
          clip_ok_d = 1'b0;
          state_d = GEN;
          if (check) chk_pend_d = 1'b1;
        end else if (check && clip_ok_q) begin
          acc_d = '0;
          idx_d = ONE;
          chk_pend_d = 1'b0;
          state_d = EVAL;
        end
      end
      GEN: begin
        buf_we = 1'b1;
        lfsr_step = 1'b1;
        idx_d = idx_q + ONE;
        if (check) chk_pend_d = 1'b1;
        if (idx_q == LAST) begin
          clip_ok_d = 1'b1;
          if (chk_pend_q || check) begin
            acc_d = '0;
            idx_d = ONE;
            chk_pend_d = 1'b0;
            state_d = EVAL;
          end else begin
            state_d = READY;
          end
        end
      end
      EVAL: begin
        acc_d = acc_q + {{IDX_W{1'b0}}, diff};
        idx_d = idx_q + ONE;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        score_d = acc_q[ACC_W-1:IDX_W];
        score_valid_d = 1'b1;
        state_d = READY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == GEN) || (state_d == EVAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      prmt_q <= '0;
      acc_q <= '0;
      score_q <= '0;
      score_valid_q <= 1'b0;
      busy_q <= 1'b0;
      clip_ok_q <= 1'b0;
      chk_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      prmt_q <= prmt_d;
      acc_q <= acc_d;
      score_q <= score_d;
      score_valid_q <= score_valid_d;
      busy_q <= busy_d;
      clip_ok_q <= clip_ok_d;
      chk_pend_q <= chk_pend_d;
    end
  end

  // Clip storage carries no reset; clip_ok gates any use of stale data
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q] <= sample;
  end

  assign score = score_q;
  assign score_valid = score_valid_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_motion_clip_scorer.sv
// Directed bench for motion_clip_scorer with a behavioural score model.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_motion_clip_scorer;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  logic make;
  logic check;
  logic [7:0] prmt;
  logic [7:0] score;
  logic score_valid;
  logic busy;

  int errors = 0;
  int checks = 0;

  motion_clip_scorer #(
    .N_SAMPLES (N),
    .SAMPLE_W  (8),
    .SEED_XOR  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .make        (make),
    .check       (check),
    .prmt        (prmt),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] p);
    logic [7:0] s [N];
    logic [7:0] l;
    logic [15:0] m;
    int acc;
    l = p ^ 8'hA5;
    if (l == 8'h00) l = 8'h01;
    for (int i = 0; i < N; i++) begin
      m = l * p;
      s[i] = m[15:8];
      if (l[0]) l = (l >> 1) ^ 8'hB8;
      else l = l >> 1;
    end
    acc = 0;
    for (int i = 1; i < N; i++) begin
      if (s[i] > s[i-1]) acc += int'(s[i]) - int'(s[i-1]);
      else acc += int'(s[i-1]) - int'(s[i]);
    end
    return 8'(acc / N);
  endfunction

  task automatic cyc(input logic mk, input logic ck, input logic [7:0] p);
    make = mk;
    check = ck;
    if (mk) prmt = p;
    @(posedge clk);
    #1;
    make = 1'b0;
    check = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_valid(input int lim, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (!got && n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (score_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks++;
    if (score !== 8'd0) begin
      errors++;
      $display("FAIL rst_score got=%0d exp=0", score);
    end
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=0", score_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_zero_prmt;
    int n;
    bit got;
    cyc(1'b1, 1'b0, 8'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy_gen got=%b exp=1", busy);
    end
    idle(20);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_ready got=%b exp=0", busy);
    end
    cyc(1'b0, 1'b1, 8'd0);
    wait_valid(40, n, got);
    checks++;
    if (!got || n != N) begin
      errors++;
      $display("FAIL zero_latency got=%0d exp=%0d seen=%0d", n, N, got);
    end
    checks++;
    if (score !== 8'd0) begin
      errors++;
      $display("FAIL zero_score got=%0d exp=0", score);
    end
    idle(1);
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got=%b exp=0", score_valid);
    end
  endtask

  task automatic test_pending_check;
    int n;
    bit got;
    logic [7:0] exp;
    exp = model(8'hC8);
    cyc(1'b1, 1'b0, 8'hC8);
    idle(2);
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(60, n, got);
    checks++;
    if (!got || n != 2 * N - 3) begin
      errors++;
      $display("FAIL pend_latency got=%0d exp=%0d seen=%0d", n, 2 * N - 3, got);
    end
    checks++;
    if (score !== exp) begin
      errors++;
      $display("FAIL pend_score got=%0d exp=%0d", score, exp);
    end
    idle(1);
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_pulse got=%b exp=0", score_valid);
    end
  endtask

  task automatic test_no_clip;
    bit seen_v;
    bit seen_b;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    cyc(1'b0, 1'b1, 8'h00);
    seen_v = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (score_valid) seen_v = 1'b1;
      if (busy) seen_b = 1'b1;
      idle(1);
    end
    checks++;
    if (seen_v !== 1'b0) begin
      errors++;
      $display("FAIL noclip_valid got=%b exp=0", seen_v);
    end
    checks++;
    if (seen_b !== 1'b0) begin
      errors++;
      $display("FAIL noclip_busy got=%b exp=0", seen_b);
    end
  endtask

  task automatic test_make_during_gen;
    int n;
    bit got;
    logic [7:0] exp;
    exp = model(8'd50);
    cyc(1'b1, 1'b0, 8'd50);
    idle(1);
    cyc(1'b1, 1'b0, 8'd200);
    idle(13);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy_gen got=%b exp=1", busy);
    end
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy_end got=%b exp=0", busy);
    end
    idle(5);
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(40, n, got);
    checks++;
    if (!got || n != N) begin
      errors++;
      $display("FAIL drop_latency got=%0d exp=%0d seen=%0d", n, N, got);
    end
    checks++;
    if (score !== exp) begin
      errors++;
      $display("FAIL drop_score got=%0d exp=%0d", score, exp);
    end
  endtask

  task automatic test_reset_in_eval;
    int n;
    bit got;
    cyc(1'b0, 1'b1, 8'h00);
    idle(4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reval_busy_pre got=%b exp=1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reval_busy got=%b exp=0", busy);
    end
    checks++;
    if (score !== 8'd0) begin
      errors++;
      $display("FAIL reval_score got=%0d exp=0", score);
    end
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("FAIL reval_valid got=%b exp=0", score_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(40, n, got);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("FAIL reval_check_ignored got=%b exp=0", got);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reval_busy_after got=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit got;
    logic [7:0] exp;
    exp = model(8'h3C);
    cyc(1'b1, 1'b1, 8'h3C);
    wait_valid(60, n, got);
    checks++;
    if (!got || n != 2 * N) begin
      errors++;
      $display("FAIL b2b_mkchk_latency got=%0d exp=%0d seen=%0d", n, 2 * N, got);
    end
    checks++;
    if (score !== exp) begin
      errors++;
      $display("FAIL b2b_score1 got=%0d exp=%0d", score, exp);
    end
    idle(1);
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse got=%b exp=0", score_valid);
    end
    cyc(1'b1, 1'b0, 8'h3C);
    idle(20);
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(40, n, got);
    checks++;
    if (!got || score !== exp) begin
      errors++;
      $display("FAIL b2b_score2 got=%0d exp=%0d seen=%0d", score, exp, got);
    end
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(40, n, got);
    checks++;
    if (!got || n != N || score !== exp) begin
      errors++;
      $display("FAIL b2b_recheck got=%0d/%0d exp=%0d/%0d", n, score, N, exp);
    end
    exp = model(8'hA5);
    cyc(1'b1, 1'b0, 8'hA5);
    idle(2);
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(60, n, got);
    checks++;
    if (!got || n != 2 * N - 3) begin
      errors++;
      $display("FAIL zseed_latency got=%0d exp=%0d seen=%0d", n, 2 * N - 3, got);
    end
    checks++;
    if (score !== exp) begin
      errors++;
      $display("FAIL zseed_score got=%0d exp=%0d", score, exp);
    end
    idle(1);
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("FAIL zseed_pulse got=%b exp=0", score_valid);
    end
    cyc(1'b0, 1'b1, 8'h00);
    wait_valid(40, n, got);
    checks++;
    if (!got || n != N || score !== exp) begin
      errors++;
      $display("FAIL zseed_recheck got=%0d/%0d exp=%0d/%0d", n, score, N, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    make = 1'b0;
    check = 1'b0;
    prmt = 8'h00;
    @(posedge clk);
    #1;
    test_reset;
    test_zero_prmt;
    test_pending_check;
    test_no_clip;
    test_make_during_gen;
    test_reset_in_eval;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
